// File: rtl/matrix_mult_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_stream_if
// Description : Streaming handshake bundle for matrix_mult_stream.
//               Input side : in_valid / in_ready / in_data ({A, B} pair).
//               Output side: out_valid / out_ready / out_data / out_last.
//               master = upstream/downstream driver, slave = the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_mult_stream_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 2*WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/matrix_mult_stream.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_stream
// Description : Streaming NxN matrix multiplier, C = A*B. Loads {A,B} element
//               pairs row-major (LOAD), computes one row of C per N cycles
//               with N MAC lanes (COMPUTE), then drains C row-major (DRAIN).
// Ports       : clk, reset (sync, active-high)
//               bus  (matrix_mult_stream_if.slave) - input/output streams
//               busy - high in COMPUTE and DRAIN
// Config      : MATMUL_SATURATE_EN defined   -> clamp results to OUT_W range
//               MATMUL_SATURATE_EN undefined -> keep low OUT_W bits (wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_stream #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int OUT_W  = 2*WIDTH,
    parameter int SIGNED = 0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    matrix_mult_stream_if.slave  bus,
    output logic                 busy
);
    localparam int ACC_W = 2*WIDTH + $clog2(N);
    localparam int K_W   = $clog2(N);
    localparam int MAXW  = (OUT_W > ACC_W) ? OUT_W : ACC_W;
    localparam logic [K_W-1:0] c_LAST = K_W'(N-1);

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

`ifdef MATMUL_SATURATE_EN
    localparam logic [MAXW-1:0] c_ONE  = MAXW'(1);
    localparam logic [MAXW-1:0] c_UMAX = (c_ONE << OUT_W) - c_ONE;
    localparam logic [MAXW-1:0] c_SMAX = (c_ONE << (OUT_W-1)) - c_ONE;
    localparam logic [MAXW-1:0] c_SMIN = ~c_SMAX;
`endif

    // Extend to a common width, optionally clamp, then narrow to OUT_W.
    function automatic logic [OUT_W-1:0] f_conv(input logic [ACC_W-1:0] v);
        logic [MAXW-1:0] ext;
        if (SIGNED != 0) ext = MAXW'($signed(v));
        else             ext = MAXW'(v);
`ifdef MATMUL_SATURATE_EN
        if (SIGNED != 0) begin
            if ($signed(ext) > $signed(c_SMAX))      ext = c_SMAX;
            else if ($signed(ext) < $signed(c_SMIN)) ext = c_SMIN;
        end else if (ext > c_UMAX) begin
            ext = c_UMAX;
        end
`endif
        return OUT_W'(ext);
    endfunction

    logic [1:0]        r_state, w_next;
    logic [K_W-1:0]    r_lr, r_lc;      // load row/col
    logic [K_W-1:0]    r_i,  r_k;       // compute row / inner index
    logic [K_W-1:0]    r_or, r_oc;      // drain row/col
    logic [WIDTH-1:0]  r_a [N][N];
    logic [WIDTH-1:0]  r_b [N][N];
    logic [OUT_W-1:0]  r_c [N][N];
    logic [ACC_W-1:0]  r_acc  [N];
    logic [ACC_W-1:0]  w_sum  [N];
    logic [OUT_W-1:0]  w_conv [N];

    logic w_in_fire, w_out_fire, w_load_done, w_comp_done, w_drain_done;

    assign w_in_fire    = bus.in_valid && bus.in_ready;
    assign w_out_fire   = bus.out_valid && bus.out_ready;
    assign w_load_done  = w_in_fire && (r_lr == c_LAST) && (r_lc == c_LAST);
    assign w_comp_done  = (r_state == S_COMPUTE) && (r_i == c_LAST) && (r_k == c_LAST);
    assign w_drain_done = w_out_fire && (r_or == c_LAST) && (r_oc == c_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    if (w_load_done)  w_next = S_COMPUTE;
            S_COMPUTE: if (w_comp_done)  w_next = S_DRAIN;
            S_DRAIN:   if (w_drain_done) w_next = S_LOAD;
            default:   w_next = S_LOAD;
        endcase
    end

    // ---------------- outputs (registered state only) ----------------
    always_comb begin
        bus.in_ready  = (r_state == S_LOAD);
        bus.out_valid = (r_state == S_DRAIN);
        bus.out_last  = (r_state == S_DRAIN) && (r_or == c_LAST) && (r_oc == c_LAST);
        busy          = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
        bus.out_data  = (r_state == S_DRAIN) ? r_c[r_or][r_oc] : '0;
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lr <= '0; r_lc <= '0;
            r_i  <= '0; r_k  <= '0;
            r_or <= '0; r_oc <= '0;
        end else begin
            if (w_in_fire) begin
                if (r_lc == c_LAST) begin
                    r_lc <= '0;
                    r_lr <= (r_lr == c_LAST) ? '0 : r_lr + K_W'(1);
                end else begin
                    r_lc <= r_lc + K_W'(1);
                end
            end
            if (r_state == S_COMPUTE) begin
                if (r_k == c_LAST) begin
                    r_k <= '0;
                    r_i <= (r_i == c_LAST) ? '0 : r_i + K_W'(1);
                end else begin
                    r_k <= r_k + K_W'(1);
                end
            end
            if (w_out_fire) begin
                if (r_oc == c_LAST) begin
                    r_oc <= '0;
                    r_or <= (r_or == c_LAST) ? '0 : r_or + K_W'(1);
                end else begin
                    r_oc <= r_oc + K_W'(1);
                end
            end
        end
    end

    // ---------------- MAC lanes: lane j builds C[i][j] ----------------
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [ACC_W-1:0] w_prod;
        if (SIGNED != 0) begin : g_signed
            logic signed [2*WIDTH-1:0] w_ps;
            assign w_ps   = $signed(r_a[r_i][r_k]) * $signed(r_b[r_k][j]);
            assign w_prod = ACC_W'(w_ps);
        end else begin : g_unsigned
            logic [2*WIDTH-1:0] w_pu;
            assign w_pu   = r_a[r_i][r_k] * r_b[r_k][j];
            assign w_prod = ACC_W'(w_pu);
        end
        // k == 0 starts a fresh dot product instead of adding to the old one
        assign w_sum[j]  = ((r_k == '0) ? '0 : r_acc[j]) + w_prod;
        assign w_conv[j] = f_conv(w_sum[j]);
    end

    // ---------------- storage (not reset; every load overwrites it all) ----------------
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_a[r_lr][r_lc] <= bus.in_data[2*WIDTH-1 -: WIDTH];
            r_b[r_lr][r_lc] <= bus.in_data[WIDTH-1:0];
        end
        if (r_state == S_COMPUTE) begin
            for (int j = 0; j < N; j++) begin
                r_acc[j] <= w_sum[j];
                if (r_k == c_LAST) r_c[r_i][j] <= w_conv[j];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mult_stream
// Description : Bench for matrix_mult_stream. An unsigned and a signed
//               instance (N=4, WIDTH=8, OUT_W=16) see identical stimulus; an
//               arithmetic model of C = A*B supplies expected output streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_stream;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int OW = 16;
`ifdef MATMUL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [2*W-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          u_busy, s_busy;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    matrix_mult_stream_if #(.WIDTH(W), .OUT_W(OW)) u_if ();
    matrix_mult_stream_if #(.WIDTH(W), .OUT_W(OW)) s_if ();

    assign u_if.in_valid  = in_valid;
    assign u_if.in_data   = in_data;
    assign u_if.out_ready = out_ready;
    assign s_if.in_valid  = in_valid;
    assign s_if.in_data   = in_data;
    assign s_if.out_ready = out_ready;

    matrix_mult_stream #(.WIDTH(W), .N(N), .OUT_W(OW), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .bus(u_if), .busy(u_busy));
    matrix_mult_stream #(.WIDTH(W), .N(N), .OUT_W(OW), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .bus(s_if), .busy(s_busy));

    logic [W-1:0]  ma [N][N];
    logic [W-1:0]  mb [N][N];
    logic [OW-1:0] qu [$];
    logic [OW-1:0] qs [$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] conv(input longint v, input bit sgn);
        if (SAT) begin
            if (sgn) begin
                if (v > 32767)  return 16'h7fff;
                if (v < -32768) return 16'h8000;
            end else if (v > 65535) begin
                return 16'hffff;
            end
        end
        return v[15:0];
    endfunction

    function automatic logic [OW-1:0] cval(input int r, input int c, input bit sgn);
        longint s, a, b;
        s = 0;
        for (int k = 0; k < N; k++) begin
            if (sgn) begin
                a = longint'($signed(ma[r][k]));
                b = longint'($signed(mb[k][c]));
            end else begin
                a = longint'(ma[r][k]);
                b = longint'(mb[k][c]);
            end
            s += a * b;
        end
        return conv(s, sgn);
    endfunction

    // ---------------- output compare ----------------
    int            obeat = 0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_u, prev_s;
    logic          prev_last;

    always @(negedge clk) begin
        if (!reset) begin
            if (u_if.out_valid || s_if.out_valid) begin
                chk("valid_pair", s_if.out_valid, u_if.out_valid);
                chk("last_u", u_if.out_last, obeat == N*N-1);
                chk("last_s", s_if.out_last, obeat == N*N-1);
                if (prev_stall) begin
                    chk("hold_u", u_if.out_data, prev_u);
                    chk("hold_s", s_if.out_data, prev_s);
                    chk("hold_last", u_if.out_last, prev_last);
                end
                if (out_ready) begin
                    if (qu.size() == 0 || qs.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_beat: got an output beat, expected none at %0t", $time);
                    end else begin
                        chk("data_u", u_if.out_data, qu.pop_front());
                        chk("data_s", s_if.out_data, qs.pop_front());
                    end
                    obeat = (obeat == N*N-1) ? 0 : obeat + 1;
                end
            end
            prev_stall = u_if.out_valid && !out_ready;
            prev_u     = u_if.out_data;
            prev_s     = s_if.out_data;
            prev_last  = u_if.out_last;
        end else begin
            obeat      = 0;
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input bit gaps);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                chk("in_ready_load", u_if.in_ready, 1);
                in_valid = 1'b1;
                in_data  = {ma[r][c], mb[r][c]};
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                qu.push_back(cval(r, c, 1'b0));
                qs.push_back(cval(r, c, 1'b1));
            end
    endtask

    // Called in the first cycle after the last accepted input beat.
    task automatic run_compute();
        int cyc;
        cyc = 1;
        chk("busy_compute", u_busy, 1);
        chk("in_ready_compute", u_if.in_ready, 0);
        in_valid = 1'b1;          // must be ignored while busy
        in_data  = 16'ha55a;
        while (!u_if.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", cyc, N*N+1);
    endtask

    task automatic drain(input bit toggle);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            done = u_if.out_valid && out_ready && u_if.out_last;
            @(posedge clk); #1;
            cyc++;
            chk("in_ready_drain", u_if.in_ready, done);
        end
        out_ready = 1'b0;
        chk("drain_done", done, 1);
        chk("queue_empty", qu.size() + qs.size(), 0);
        chk("busy_after", u_busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", u_if.in_ready, 1);
        chk("rst_out_valid", u_if.out_valid, 0);
        chk("rst_out_last", u_if.out_last, 0);
        chk("rst_busy", u_busy, 0);
        chk("rst_out_data", u_if.out_data, 0);
        reset = 1'b0;

        // identity times an index matrix -> 0..15
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 8'd1 : 8'd0;
                mb[r][c] = W'(r*4 + c);
            end
        chk("pin_id_u", cval(2, 3, 1'b0), 11);
        chk("pin_id_s", cval(3, 0, 1'b1), 12);
        load(1'b0); run_compute(); drain(1'b0);

        // all 255: unsigned 260100, signed (-1) -> 4
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin ma[r][c] = 8'hff; mb[r][c] = 8'hff; end
        chk("pin_ovf_u", cval(1, 2, 1'b0), SAT ? 65535 : 63492);
        chk("pin_ovf_s", cval(0, 0, 1'b1), 4);
        load(1'b0); run_compute(); drain(1'b0);

        // all -128: exact 65536 both interpretations
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin ma[r][c] = 8'h80; mb[r][c] = 8'h80; end
        chk("pin_neg_s", cval(0, 0, 1'b1), SAT ? 32767 : 0);
        chk("pin_neg_u", cval(3, 1, 1'b0), SAT ? 65535 : 0);
        load(1'b0); run_compute(); drain(1'b0);

        // A=-128, B=127: signed -65024
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin ma[r][c] = 8'h80; mb[r][c] = 8'h7f; end
        chk("pin_mix_s", cval(3, 3, 1'b1), SAT ? 16'h8000 : 512);
        chk("pin_mix_u", cval(2, 2, 1'b0), 65024);
        load(1'b0); run_compute(); drain(1'b0);

        // mixed values with backpressure, then again with input gaps
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = W'(r*37 + c*11 + 5);
                mb[r][c] = W'(200 - r*13 - c*29);
            end
        load(1'b0); run_compute(); drain(1'b1);
        load(1'b1); run_compute(); drain(1'b0);

        // reset in the middle of COMPUTE, then a fresh load
        load(1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", u_if.in_ready, 1);
        chk("midrst_out_valid", u_if.out_valid, 0);
        chk("midrst_busy", u_busy, 0);
        reset = 1'b0;
        qu.delete();
        qs.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = W'(c*50 + r*3 + 1);
                mb[r][c] = W'(r*60 + c*9 + 7);
            end
        load(1'b0); run_compute(); drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
